// File: rtl/i2cmb_cmd_sequencer.sv
// Drives one I2C byte transaction (bus select, start, address, data, stop) through the
// IICMB Wishbone register interface and reports a 2-bit completion status per request.
module i2cmb_cmd_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // Request/response handshake: a request transfers on a cycle where req_valid && req_ready;
  // req_ready is high only while idle. rsp_valid is a one-cycle pulse with no back-pressure.
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_bus,
  input  logic [6:0]               req_addr,
  input  logic                     req_rw,
  input  logic [7:0]               req_wdata,
  output logic                     rsp_valid,
  output logic [1:0]               rsp_status,
  output logic [7:0]               rsp_rdata,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  input  logic                     ack_i,
  input  logic                     irq_i
);

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_SETBUS_DPR, ST_SETBUS_CMD, ST_START_CMD, ST_ADDR_DPR, ST_ADDR_CMD,
    ST_DATA_DPR, ST_DATA_CMD, ST_RDDPR, ST_STOP_CMD, ST_WAIT, ST_WAIT_RD, ST_RESP
  } state_t;

  typedef enum logic [2:0] {CMD_SETBUS, CMD_START, CMD_ADDR, CMD_DATA, CMD_STOP} cmd_t;

  localparam logic [1:0]  REG_CSR = 2'd0;
  localparam logic [1:0]  REG_DPR = 2'd1;
  localparam logic [1:0]  REG_CMDR = 2'd2;
  localparam logic [1:0]  STS_OK = 2'b00;
  localparam logic [1:0]  STS_NAK = 2'b01;
  localparam logic [1:0]  STS_AL = 2'b10;
  localparam logic [1:0]  STS_ERR = 2'b11;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_d;
  cmd_t        cmd, cmd_d;
  logic [3:0]  bus_q;
  logic [6:0]  addr_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rd_q;
  logic [1:0]  sts_q;
  logic        sts_set;
  logic [15:0] cnt;

  logic        acc_start, acc_we, acc_done;
  logic [1:0]  acc_adr;
  logic [7:0]  acc_dat;
  logic        sts_wr, capture, rd_capture;
  logic [1:0]  sts_val, sts_final;
  logic [7:0]  rd_byte;

  assign acc_done  = cyc_o & ack_i;
  assign rd_byte   = dat_i[7:0];
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign sts_final = sts_set ? sts_q : (sts_wr ? sts_val : STS_OK);

  always_comb begin
    state_d    = state;
    cmd_d      = cmd;
    acc_start  = 1'b0;
    acc_we     = 1'b0;
    acc_adr    = REG_CSR;
    acc_dat    = 8'h00;
    sts_wr     = 1'b0;
    sts_val    = STS_OK;
    capture    = 1'b0;
    rd_capture = 1'b0;
    unique case (state)
      ST_INIT: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_CSR; acc_dat = 8'hC0;
        if (acc_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          state_d = ST_SETBUS_DPR;
        end
      end
      ST_SETBUS_DPR: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_DPR; acc_dat = {4'h0, bus_q};
        if (acc_done) state_d = ST_SETBUS_CMD;
      end
      ST_SETBUS_CMD: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_CMDR; acc_dat = 8'h06;
        if (acc_done) begin cmd_d = CMD_SETBUS; state_d = ST_WAIT; end
      end
      ST_START_CMD: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_CMDR; acc_dat = 8'h04;
        if (acc_done) begin cmd_d = CMD_START; state_d = ST_WAIT; end
      end
      ST_ADDR_DPR: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_DPR; acc_dat = {addr_q, rw_q};
        if (acc_done) state_d = ST_ADDR_CMD;
      end
      ST_ADDR_CMD: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_CMDR; acc_dat = 8'h01;
        if (acc_done) begin cmd_d = CMD_ADDR; state_d = ST_WAIT; end
      end
      ST_DATA_DPR: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_DPR; acc_dat = wdata_q;
        if (acc_done) state_d = ST_DATA_CMD;
      end
      ST_DATA_CMD: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_CMDR; acc_dat = rw_q ? 8'h03 : 8'h01;
        if (acc_done) begin cmd_d = CMD_DATA; state_d = ST_WAIT; end
      end
      ST_RDDPR: begin
        acc_start = 1'b1; acc_adr = REG_DPR;
        if (acc_done) begin rd_capture = 1'b1; state_d = ST_STOP_CMD; end
      end
      ST_STOP_CMD: begin
        acc_start = 1'b1; acc_we = 1'b1; acc_adr = REG_CMDR; acc_dat = 8'h05;
        if (acc_done) begin cmd_d = CMD_STOP; state_d = ST_WAIT; end
      end
      ST_WAIT: begin
        // irq wins over a timeout expiring on the same cycle; a timeout never issues STOP
        if (irq_i) state_d = ST_WAIT_RD;
        else if (cnt == TO_LAST) begin
          sts_wr = 1'b1; sts_val = STS_ERR; state_d = ST_RESP;
        end
      end
      ST_WAIT_RD: begin
        acc_start = 1'b1; acc_adr = REG_CMDR;
        if (acc_done) begin
          if (rd_byte[5]) begin
            sts_wr = 1'b1; sts_val = STS_AL; state_d = ST_RESP;
          end else if (rd_byte[4] || !(rd_byte[6] || rd_byte[7])) begin
            sts_wr = 1'b1; sts_val = STS_ERR;
            state_d = (cmd == CMD_STOP) ? ST_RESP : ST_STOP_CMD;
          end else if (rd_byte[6]) begin
            sts_wr = 1'b1; sts_val = STS_NAK;
            state_d = (cmd == CMD_STOP) ? ST_RESP : ST_STOP_CMD;
          end else begin
            unique case (cmd)
              CMD_SETBUS: state_d = ST_START_CMD;
              CMD_START:  state_d = ST_ADDR_DPR;
              CMD_ADDR:   state_d = rw_q ? ST_DATA_CMD : ST_DATA_DPR;
              CMD_DATA:   state_d = rw_q ? ST_RDDPR : ST_STOP_CMD;
              default:    state_d = ST_RESP;
            endcase
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_INIT;
      cmd   <= CMD_SETBUS;
    end else begin
      state <= state_d;
      cmd   <= cmd_d;
    end
  end

  // Wishbone engine: a request is only taken while cyc_o is low, so there is always one
  // idle cycle between the ack and the next access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
    end else if (cyc_o) begin
      if (ack_i) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        we_o  <= 1'b0;
        adr_o <= '0;
        dat_o <= '0;
      end
    end else if (acc_start) begin
      cyc_o <= 1'b1;
      stb_o <= 1'b1;
      we_o  <= acc_we;
      adr_o <= WB_ADDR_WIDTH'(acc_adr);
      dat_o <= WB_DATA_WIDTH'(acc_dat);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      rd_q       <= '0;
      sts_q      <= STS_OK;
      sts_set    <= 1'b0;
      cnt        <= '0;
      rsp_status <= STS_OK;
      rsp_rdata  <= '0;
    end else begin
      if (capture) begin
        bus_q   <= req_bus;
        addr_q  <= req_addr;
        rw_q    <= req_rw;
        wdata_q <= req_wdata;
        rd_q    <= '0;
        sts_q   <= STS_OK;
        sts_set <= 1'b0;
      end else begin
        if (rd_capture) rd_q <= rd_byte;
        // the first failure sticks; later ones (e.g. from STOP) are dropped
        if (sts_wr && !sts_set) begin
          sts_q   <= sts_val;
          sts_set <= 1'b1;
        end
      end
      cnt <= (state == ST_WAIT) ? cnt + 16'd1 : 16'd0;
      if (state_d == ST_RESP && state != ST_RESP) begin
        rsp_status <= sts_final;
        rsp_rdata  <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Bench for i2cmb_cmd_sequencer: a behavioural IICMB register slave plus scoreboards for the
// Wishbone access stream and the response stream, driven by directed I2C transactions.
module tb_i2cmb_cmd_sequencer;
  localparam int TO = 100;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_valid, req_ready, req_rw;
  logic [3:0] req_bus;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o, dat_i;
  logic       ack_i, irq_i;

  i2cmb_cmd_sequencer #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  // expected Wishbone accesses {we, adr, dat(writes only)} and responses {status, rdata}
  logic [10:0] exp_q[$];
  logic [9:0]  exp_rsp_q[$];
  // slave CMDR read-back per CMDR write: {suppress_irq, value}
  logic [8:0]  cmdr_q[$];

  logic [7:0]  cmdr_val, dpr_rd;
  logic [8:0]  entry;
  logic [10:0] wb_act, wb_exp;
  logic [9:0]  rsp_exp;
  int          ws, irq_cnt;
  bit          ack_en = 1'b1;
  int          stray_req = 0, stray_done = 0;
  int          n_cmd_wr = 0, n_rsp = 0, last_cmd_cyc = 0, to_latency = 0;

  // ---------------- IICMB register slave ----------------
  initial begin
    ack_i = 1'b0; dat_i = 8'h00; irq_i = 1'b0; ws = -1; irq_cnt = 0; cmdr_val = 8'h80;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        ack_i = 1'b0; irq_i = 1'b0; ws = -1; irq_cnt = 0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) irq_i = 1'b1;
        end
        if (ack_i) ack_i = 1'b0;
        else if (stray_req != stray_done && !cyc_o) begin
          ack_i = 1'b1; stray_done++;
        end else if (cyc_o && stb_o && ack_en) begin
          if (ws < 0) ws = $urandom_range(0, 2);
          if (ws == 0) begin
            ack_i = 1'b1; ws = -1; dat_i = 8'h00;
            if (we_o && adr_o == 2'd2) begin
              entry = (cmdr_q.size() > 0) ? cmdr_q.pop_front() : 9'h080;
              cmdr_val = entry[7:0];
              if (!entry[8]) irq_cnt = 3;
            end else if (!we_o && adr_o == 2'd2) begin
              dat_i = cmdr_val; irq_i = 1'b0;
            end else if (!we_o && adr_o == 2'd1) dat_i = dpr_rd;
          end else ws--;
        end
      end
    end
  end

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk_i) begin
    if (!rst_i && cyc_o && stb_o && ack_i) begin
      wb_act = {we_o, adr_o, we_o ? dat_o : 8'h00};
      if (we_o && adr_o == 2'd2) begin
        n_cmd_wr++; last_cmd_cyc = cyc_cnt;
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL wb_access: got we=%0b adr=%0d dat=%02h, required no access", we_o, adr_o, dat_o);
      end else begin
        wb_exp = exp_q.pop_front();
        if (wb_act !== wb_exp) begin
          n_errors++;
          $display("FAIL wb_access: got we=%0b adr=%0d dat=%02h, required we=%0b adr=%0d dat=%02h",
                   wb_act[10], wb_act[9:8], wb_act[7:0], wb_exp[10], wb_exp[9:8], wb_exp[7:0]);
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid) begin
      n_rsp++;
      to_latency = cyc_cnt - last_cmd_cyc;
      n_checks++;
      if (exp_rsp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rsp: got status=%02b rdata=%02h, required no response", rsp_status, rsp_rdata);
      end else begin
        rsp_exp = exp_rsp_q.pop_front();
        if ({rsp_status, rsp_rdata} !== rsp_exp) begin
          n_errors++;
          $display("FAIL rsp: got status=%02b rdata=%02h, required status=%02b rdata=%02h",
                   rsp_status, rsp_rdata, rsp_exp[9:8], rsp_exp[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i); #1;
  endtask

  task automatic push_w(input logic [1:0] adr, input logic [7:0] dat);
    exp_q.push_back({1'b1, adr, dat});
  endtask

  task automatic push_r(input logic [1:0] adr);
    exp_q.push_back({1'b0, adr, 8'h00});
  endtask

  // CMDR write, then (unless the slave withholds irq) the CMDR read-back returning rsp
  task automatic push_cmd(input logic [7:0] cmd, input logic [7:0] rsp, input bit noirq);
    push_w(2'd2, cmd);
    cmdr_q.push_back({noirq, rsp});
    if (!noirq) push_r(2'd2);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 500; i++) begin
      if (req_ready) break;
      step();
    end
    check(name, req_ready, 1);
  endtask

  task automatic run_req(input logic [3:0] bus, input logic [6:0] addr, input logic rw,
                         input logic [7:0] wdata, input logic [1:0] sts, input logic [7:0] rdata,
                         input bit wait_rsp);
    int base;
    base = n_rsp;
    if (wait_rsp) exp_rsp_q.push_back({sts, rdata});
    wait_ready("req_ready_idle");
    req_bus = bus; req_addr = addr; req_rw = rw; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk_i); #1;
    // scramble the request lines and pulse valid while busy; none of it may be taken
    req_valid = 1'b0;
    req_bus = 4'($urandom); req_addr = 7'($urandom); req_rw = 1'($urandom); req_wdata = 8'($urandom);
    step(); step();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    if (wait_rsp) begin
      for (int i = 0; i < 3000; i++) begin
        if (n_rsp != base) break;
        step();
      end
      check("rsp_seen", n_rsp - base, 1);
      step();
      check("rsp_pulse_one_cycle", rsp_valid, 0);
      check("ready_after_resp", req_ready, 1);
      check("rsp_hold", {rsp_status, rsp_rdata}, {sts, rdata});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int rsp_before;
    rst_i = 1'b1; req_valid = 1'b0; req_bus = '0; req_addr = '0; req_rw = 1'b0; req_wdata = '0;
    dpr_rd = 8'h3C;
    step(); step(); step();
    check("reset_outputs", {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid, rsp_status, rsp_rdata}, 0);

    // first access after reset is the CSR enable write
    push_w(2'd0, 8'hC0);
    rst_i = 1'b0;
    step();
    check("ready_low_in_init", req_ready, 0);
    wait_ready("ready_after_init");
    check("init_single_write", exp_q.size(), 0);

    // stray acks while idle
    stray_req++;
    step(); step();
    stray_req++;
    step(); step();

    // write bus 0, slave 0x22, data 0xA5, all ACKed
    push_w(2'd1, 8'h00); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'h44); push_cmd(8'h01, 8'h80, 0);
    push_w(2'd1, 8'hA5); push_cmd(8'h01, 8'h80, 0); push_cmd(8'h05, 8'h80, 0);
    run_req(4'd0, 7'h22, 1'b0, 8'hA5, 2'b00, 8'h00, 1);

    // read slave 0x22 returning 0x3C
    push_w(2'd1, 8'h00); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'h45); push_cmd(8'h01, 8'h80, 0);
    push_cmd(8'h03, 8'h80, 0); push_r(2'd1); push_cmd(8'h05, 8'h80, 0);
    run_req(4'd0, 7'h22, 1'b1, 8'h00, 2'b00, 8'h3C, 1);

    // absent slave: address NAK, no data phase, STOP issued
    push_w(2'd1, 8'h03); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'hA0); push_cmd(8'h01, 8'h40, 0); push_cmd(8'h05, 8'h80, 0);
    run_req(4'd3, 7'h50, 1'b0, 8'h77, 2'b01, 8'h00, 1);

    // AL and ERR together on START: AL wins, no STOP, rdata cleared from previous read
    push_w(2'd1, 8'h02); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h30, 0);
    run_req(4'd2, 7'h10, 1'b1, 8'h00, 2'b10, 8'h00, 1);

    // ERR+NAK on data write -> ERR; STOP then NAKs but must not overwrite status
    push_w(2'd1, 8'h05); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'h54); push_cmd(8'h01, 8'h80, 0);
    push_w(2'd1, 8'hC3); push_cmd(8'h01, 8'h50, 0); push_cmd(8'h05, 8'h40, 0);
    run_req(4'd5, 7'h2A, 1'b0, 8'hC3, 2'b11, 8'h00, 1);

    // NAK+DON on data read -> NAK, DPR never read, STOP issued
    push_w(2'd1, 8'h01); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'h45); push_cmd(8'h01, 8'h80, 0);
    push_cmd(8'h03, 8'hC0, 0); push_cmd(8'h05, 8'h80, 0);
    run_req(4'd1, 7'h22, 1'b1, 8'h00, 2'b01, 8'h00, 1);

    // irq never arrives after ADDR: response TO cycles after WAIT entry, no STOP
    push_w(2'd1, 8'h01); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'h67); push_cmd(8'h01, 8'h00, 1);
    run_req(4'd1, 7'h33, 1'b1, 8'h00, 2'b11, 8'h00, 1);
    // ack seen in cycle N, WAIT entered in N+1, RESP TO cycles later
    check("timeout_latency", to_latency, TO + 1);

    // reset pulsed while waiting on ADDR
    push_w(2'd1, 8'h00); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'hA0); push_cmd(8'h01, 8'h00, 1);
    base = n_cmd_wr;
    rsp_before = n_rsp;
    run_req(4'd0, 7'h50, 1'b0, 8'h11, 2'b00, 8'h00, 0);
    for (int i = 0; i < 300; i++) begin
      if (n_cmd_wr - base == 3) break;
      step();
    end
    check("addr_cmd_issued", n_cmd_wr - base, 3);
    step(); step(); step(); step(); step();
    #2 rst_i = 1'b1;
    #1 check("reset_abort_outputs", {cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid, rsp_status, rsp_rdata}, 0);
    cmdr_q.delete();
    ack_en = 1'b0;
    step(); step();
    rst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cyc_o) break;
      step();
    end
    check("init_rerun_cyc", {cyc_o, we_o, adr_o, dat_o}, {1'b1, 1'b1, 2'd0, 8'hC0});
    #2 rst_i = 1'b1;
    #1 check("async_cyc_drop", {cyc_o, stb_o}, 0);
    step();
    ack_en = 1'b1;
    push_w(2'd0, 8'hC0);
    rst_i = 1'b0;
    wait_ready("ready_after_reinit");
    check("no_rsp_for_aborted", n_rsp - rsp_before, 0);

    // recovery write after the abort
    push_w(2'd1, 8'h09); push_cmd(8'h06, 8'h80, 0); push_cmd(8'h04, 8'h80, 0);
    push_w(2'd1, 8'hFE); push_cmd(8'h01, 8'h80, 0);
    push_w(2'd1, 8'h5A); push_cmd(8'h01, 8'h80, 0); push_cmd(8'h05, 8'h80, 0);
    run_req(4'd9, 7'h7F, 1'b0, 8'h5A, 2'b00, 8'h00, 1);

    step(); step(); step();
    check("wb_queue_drained", exp_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    check("cmdr_queue_drained", cmdr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within 500000 time units");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2cmb_cmd_sequencer.md
I2CMB_CMD_SEQUENCER -- requirements
Module: i2cmb_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 The block SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clk_i cycles to wait for irq_i per command.
REQ-004 The block SHALL have ports as follows (one clock; reset is asynchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid  in  1  transaction request
- req_ready  out  1  sequencer can accept a request
- req_bus  in  4  target I2C bus index
- req_addr  in  7  I2C slave address
- req_rw  in  1  1 = read, 0 = write
- req_wdata  in  8  write byte
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  2  00 OK, 01 NAK, 10 arbitration lost, 11 error/timeout
- rsp_rdata  out  8  read byte (valid with rsp_valid when read and OK)
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  WB_ADDR_WIDTH  register select (0 CSR, 1 DPR, 2 CMDR)
- dat_o  out  WB_DATA_WIDTH  write data
- dat_i  in  WB_DATA_WIDTH  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  IICMB command-done interrupt

Function
REQ-005 Wishbone access: cyc_o, stb_o, we_o, adr_o, dat_o SHALL assert together and hold until ack_i is sampled high; cyc_o/stb_o SHALL drop the following cycle; the next access SHALL NOT start before the cycle after that.
REQ-006 After reset the FSM SHALL perform exactly one write CSR=0xC0 (enable + IE) in state INIT before entering IDLE.
REQ-007 req_ready SHALL be 1 only in IDLE; a request SHALL be captured into internal registers on the cycle req_valid && req_ready.
REQ-008 Sequence: SETBUS (DPR=req_bus, CMDR=0x06), START (CMDR=0x04), ADDR (DPR={req_addr,req_rw}, CMDR=0x01), DATA (write: DPR=req_wdata, CMDR=0x01; read: CMDR=0x03), RDDPR (read only: read DPR into rsp_rdata), STOP (CMDR=0x05), RESP.
REQ-009 After every CMDR write the FSM SHALL enter WAIT: hold until irq_i=1, then read CMDR (adr 2), which clears irq_i in the controller.
REQ-010 CMDR read decode, priority high to low: bit5 (AL) -> status 10, skip STOP, go to RESP; bit4 (ERR) -> status 11, go to STOP; bit6 (NAK) -> status 01, go to STOP; bit7 (DON) -> continue sequence.
REQ-011 A NAK on ADDR SHALL skip DATA and RDDPR; a NAK on the DATA write SHALL skip to STOP.
REQ-012 Timeout: a 16-bit counter SHALL clear on WAIT entry; at TIMEOUT_CYCLES without irq_i the status SHALL be 11 and the FSM SHALL enter RESP without STOP.
REQ-013 The first status recorded SHALL be kept; a STOP completion SHALL NOT overwrite it.
REQ-014 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_status/rsp_rdata SHALL hold until the next RESP.
REQ-015 A req_valid deasserted or changed while the FSM is busy SHALL be ignored.
REQ-016 An ack_i seen while cyc_o=0 SHALL be ignored.

Reset
REQ-017 While rst_i=1, all outputs SHALL be 0 (cyc_o, stb_o, we_o, adr_o, dat_o, req_ready, rsp_valid, rsp_status, rsp_rdata), the FSM SHALL be in INIT, and the counter SHALL be cleared.
REQ-018 Reset asserted mid-transaction SHALL abort immediately, drop cyc_o/stb_o asynchronously, and re-run INIT after release; no rsp_valid SHALL be produced for the aborted request.

Verification
REQ-019 After reset release -> first Wishbone access is a write with adr=0, dat=0xC0; req_ready=1 after its ack.
REQ-020 Write request bus=0, addr=0x22, wdata=0xA5 with I2C slave ACKing -> CMDR writes 06,04,01,01,05 in order; DPR writes 0x00, 0x44, 0xA5; rsp_status=00.
REQ-021 Read request addr=0x22 with slave returning 0x3C -> DPR=0x45, CMDR 0x03, DPR read; rsp_rdata=0x3C, status 00.
REQ-022 Absent slave (address NAK, CMDR read 0x40) -> no DATA access, STOP issued, rsp_status=01.
REQ-023 irq_i held 0 with TIMEOUT_CYCLES=100 -> rsp_valid exactly 100 cycles after WAIT entry, status 11, no STOP write.
REQ-024 rst_i pulsed during ADDR WAIT -> cyc_o=0 immediately, no rsp_valid, and a CSR=0xC0 write after release.
